cc_coef_scheduler: RTL

CC_COEF_SCHEDULER -- requirements
Module: cc_coef_scheduler

---
 rtl/cc_coef_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cc_coef_scheduler.sv
// Coefficient scheduler for the color corrector: buffers a shadow coefficient set and,
// on request, stalls the stream at the next frame start, drains it, and loads all 12 coefficients.
module cc_coef_scheduler #(
  parameter  int PX_WIDTH    = 10,
  parameter  int FRACT_WIDTH = 10,
  localparam int COEF_WIDTH  = PX_WIDTH + FRACT_WIDTH,
  localparam int TDATA_WIDTH = ((3 * PX_WIDTH + 7) / 8) * 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   csr_wr_i,
  input  logic [3:0]             csr_sel_i,
  input  logic [COEF_WIDTH:0]    csr_coef_i,
  input  logic                   commit_i,
  output logic                   busy_o,
  output logic                   commit_done_o,
  input  logic                   s_tvalid_i,
  output logic                   s_tready_o,
  input  logic [TDATA_WIDTH-1:0] s_tdata_i,
  input  logic                   s_tuser_i,
  input  logic                   s_tlast_i,
  output logic                   m_tvalid_o,
  input  logic                   m_tready_i,
  output logic [TDATA_WIDTH-1:0] m_tdata_o,
  output logic                   m_tuser_o,
  output logic                   m_tlast_o,
  input  logic                   cc_out_hs_i,
  output logic [COEF_WIDTH:0]    cc_coef_o,
  output logic [3:0]             cc_coef_sel_o,
  output logic                   cc_coef_lock_o,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DRAIN = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int                NUM_COEF = 12;
  localparam logic [COEF_WIDTH:0] COEF_ONE = (COEF_WIDTH + 1)'(1) << FRACT_WIDTH;

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic [3:0]          inflight_q, inflight_d;
  logic                lock_q, lock_d;
  logic [3:0]          sel_q, sel_d;
  logic [COEF_WIDTH:0] coef_q, coef_d;
  logic [COEF_WIDTH:0] shadow_q [NUM_COEF];
  logic [COEF_WIDTH:0] shadow_d [NUM_COEF];
  logic                open;
  logic                shadow_we;
  logic [3:0]          load_sel;
  logic                sof_seen;

  // Stream valid/ready: a beat transfers on a cycle where tvalid & tready are both high;
  // the gate only masks both directions, data/user/last pass straight through.
  assign sof_seen = s_tvalid_i & s_tuser_i;

  always_comb begin
    open = 1'b1;
    case (state_q)
      ST_ARMED: open = ~sof_seen;
      ST_DRAIN: open = 1'b0;
      ST_LOAD:  open = 1'b0;
      default:  open = 1'b1;
    endcase
  end

  assign m_tvalid_o = s_tvalid_i & open;
  assign s_tready_o = m_tready_i & open;
  assign m_tdata_o  = s_tdata_i;
  assign m_tuser_o  = s_tuser_i;
  assign m_tlast_o  = s_tlast_i;

  always_comb begin
    inflight_d = inflight_q;
    if ((m_tvalid_o & m_tready_i) && !cc_out_hs_i) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!(m_tvalid_o & m_tready_i) && cc_out_hs_i) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  assign shadow_we = csr_wr_i && (csr_sel_i < 4'(NUM_COEF)) &&
                     (state_q == ST_IDLE || state_q == ST_ARMED);

  always_comb begin
    for (int i = 0; i < NUM_COEF; i++) begin
      shadow_d[i] = shadow_q[i];
      if (shadow_we && csr_sel_i == 4'(i)) begin
        shadow_d[i] = csr_coef_i;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    lock_d    = 1'b0;
    sel_d     = sel_q;
    coef_d    = coef_q;
    load_sel  = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (commit_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (sof_seen) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (commit_i) pending_d = 1'b1;
        // Leave as soon as the last outstanding pixel retires this cycle.
        if (inflight_d == 4'd0) begin
          state_d  = ST_LOAD;
          lock_d   = 1'b1;
          load_sel = 4'd0;
        end
      end
      ST_LOAD: begin
        if (commit_i) pending_d = 1'b1;
        if (sel_q == 4'(NUM_COEF - 1)) begin
          state_d = ST_DONE;
        end else begin
          lock_d   = 1'b1;
          load_sel = sel_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d   = (pending_q || commit_i) ? ST_ARMED : ST_IDLE;
        pending_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (lock_d) begin
      sel_d = load_sel;
      for (int i = 0; i < NUM_COEF; i++) begin
        if (load_sel == 4'(i)) coef_d = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      inflight_q <= 4'd0;
      lock_q     <= 1'b0;
      sel_q      <= 4'd0;
      coef_q     <= '0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= (i == 0 || i == 5 || i == 10) ? COEF_ONE : '0;
      end
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      lock_q     <= lock_d;
      sel_q      <= sel_d;
      coef_q     <= coef_d;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign commit_done_o  = (state_q == ST_DONE);
  assign cc_coef_lock_o = lock_q;
  assign cc_coef_sel_o  = sel_q;
  assign cc_coef_o      = coef_q;
  assign dbg_state_o    = state_q;

endmodule
